// File: rtl/gray_counter_encoder_if.sv
// gray_counter_encoder_if: step/load controls and registered count outputs; err port exists only with GRAY_COUNTER_CHECK_EN
interface gray_counter_encoder_if #(
  parameter int WIDTH = 8,
  parameter int IDXW = $clog2(WIDTH)
);
  logic en;
  logic up_dn;
  logic load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] binary;
  logic [WIDTH-1:0] gray;
  logic wrap;
  logic flip_valid;
  logic [IDXW-1:0] flip_idx;
`ifdef GRAY_COUNTER_CHECK_EN
  logic err;
  modport master (output en, up_dn, load, load_bin, input binary, gray, wrap, flip_valid, flip_idx, err);
  modport slave (input en, up_dn, load, load_bin, output binary, gray, wrap, flip_valid, flip_idx, err);
`else
  modport master (output en, up_dn, load, load_bin, input binary, gray, wrap, flip_valid, flip_idx);
  modport slave (input en, up_dn, load, load_bin, output binary, gray, wrap, flip_valid, flip_idx);
`endif
endinterface

// File: rtl/gray_counter_encoder.sv
// gray_counter_encoder: up/down binary counter with registered Gray image and toggled-bit report; GRAY_COUNTER_CHECK_EN adds a single-bit-change checker
module gray_counter_encoder #(
  parameter int WIDTH = 8,
  parameter int IDXW = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst,
  gray_counter_encoder_if.slave bus
);
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] scan;
  logic [IDXW-1:0] idx;
  // next count, and the Gray bit a step toggles: lowest 0 bit going up, lowest 1 bit going down, top bit on wrap
  always_comb begin
    nxt = bus.up_dn ? bus.binary + 1'b1 : bus.binary - 1'b1;
    scan = bus.up_dn ? ~bus.binary : bus.binary;
    idx = IDXW'(WIDTH - 1);
    for (int i = WIDTH - 1; i >= 0; i--) if (scan[i]) idx = IDXW'(i);
  end
  // count register with its Gray image computed from the next value so it never lags
  always_ff @(posedge clk)
    if (rst) begin
      bus.binary <= '0;
      bus.gray <= '0;
      bus.wrap <= 1'b0;
      bus.flip_valid <= 1'b0;
      bus.flip_idx <= '0;
    end else if (bus.load) begin
      bus.binary <= bus.load_bin;
      bus.gray <= bus.load_bin ^ (bus.load_bin >> 1);
      bus.wrap <= 1'b0;
      bus.flip_valid <= 1'b0;
    end else if (bus.en) begin
      bus.binary <= nxt;
      bus.gray <= nxt ^ (nxt >> 1);
      bus.wrap <= bus.up_dn ? &bus.binary : ~|bus.binary;
      bus.flip_valid <= 1'b1;
      bus.flip_idx <= idx;
    end else begin
      bus.wrap <= 1'b0;
      bus.flip_valid <= 1'b0;
    end
`ifdef GRAY_COUNTER_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] diff;
  assign diff = bus.gray ^ prev_gray;
  // after each step the Gray code must have moved by exactly the reported bit
  always_ff @(posedge clk)
    if (rst) begin
      prev_gray <= '0;
      bus.err <= 1'b0;
    end else begin
      prev_gray <= bus.gray;
      bus.err <= bus.flip_valid && ($countones(diff) != 1 || !diff[bus.flip_idx]);
    end
`endif
endmodule

// File: tb/tb_gray_counter_encoder.sv
// tb_gray_counter_encoder: directed vectors plus a per-cycle arithmetic model of the Gray counter
module tb_gray_counter_encoder;
  localparam int W = 8;
  localparam int M = 2 ** W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gray_counter_encoder_if #(.WIDTH(W)) bus_if ();
  gray_counter_encoder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus_if));
  int n_pass = 0;
  int n_tot = 0;
  int m_bin = 0;
  int m_wrap = 0;
  int m_fv = 0;
  int m_idx = 0;
  bit chk_on = 1'b0;
  logic [W-1:0] prev_g = '0;
  int eb[5] = '{1, 2, 3, 4, 5};
  int eg[5] = '{'h01, 'h03, 'h02, 'h06, 'h07};
  int ei[5] = '{0, 1, 0, 2, 0};
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  function automatic int g(int b);
    return b ^ (b >> 1);
  endfunction
  task automatic cyc(bit r, bit ld, int lb, bit e, bit ud);
    int t;
    rst = r;
    bus_if.load = ld;
    bus_if.load_bin = W'(lb);
    bus_if.en = e;
    bus_if.up_dn = ud;
    @(posedge clk);
    if (r) begin
      m_bin = 0; m_wrap = 0; m_fv = 0; m_idx = 0;
    end else if (ld) begin
      m_bin = lb % M; m_wrap = 0; m_fv = 0;
    end else if (e) begin
      t = 0;
      if (ud) begin
        while (t < W - 1 && ((m_bin >> t) % 2) == 1) t++;
        m_wrap = (m_bin == M - 1) ? 1 : 0;
        m_bin = (m_bin + 1) % M;
      end else begin
        while (t < W - 1 && ((m_bin >> t) % 2) == 0) t++;
        m_wrap = (m_bin == 0) ? 1 : 0;
        m_bin = (m_bin + M - 1) % M;
      end
      m_idx = t; m_fv = 1;
    end else begin
      m_wrap = 0; m_fv = 0;
    end
    #1;
  endtask
  always @(negedge clk) begin
    if (chk_on) begin
      chk("binary", 32'(bus_if.binary), m_bin);
      chk("gray", 32'(bus_if.gray), g(m_bin));
      chk("wrap", 32'(bus_if.wrap), m_wrap);
      chk("flip_valid", 32'(bus_if.flip_valid), m_fv);
      chk("flip_idx", 32'(bus_if.flip_idx), m_idx);
      if (m_fv == 1) begin
        chk("one_bit_change", $countones(bus_if.gray ^ prev_g), 1);
        chk("flip_bit", 32'(bus_if.gray[bus_if.flip_idx] ^ prev_g[bus_if.flip_idx]), 1);
      end
`ifdef GRAY_COUNTER_CHECK_EN
      chk("err", 32'(bus_if.err), 0);
`endif
    end
    prev_g = bus_if.gray;
  end
  initial begin
    bit ud;
    bus_if.en = 1'b0;
    bus_if.up_dn = 1'b1;
    bus_if.load = 1'b0;
    bus_if.load_bin = '0;
    cyc(1, 0, 0, 0, 1);
    chk_on = 1'b1;
    cyc(1, 0, 0, 0, 1);
    chk("rst_binary", 32'(bus_if.binary), 0);
    chk("rst_gray", 32'(bus_if.gray), 0);
    chk("rst_flags", {bus_if.wrap, bus_if.flip_valid}, 0);
    chk("rst_idx", 32'(bus_if.flip_idx), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 1);
      chk("up_binary", 32'(bus_if.binary), eb[i]);
      chk("up_gray", 32'(bus_if.gray), eg[i]);
      chk("up_idx", 32'(bus_if.flip_idx), ei[i]);
      chk("up_wrap", 32'(bus_if.wrap), 0);
    end
    cyc(0, 0, 0, 0, 1);
    chk("hold_binary", 32'(bus_if.binary), 5);
    chk("hold_fv", 32'(bus_if.flip_valid), 0);
    cyc(0, 1, 'hFE, 0, 1);
    cyc(0, 0, 0, 1, 1);
    chk("upwrap_ff", 32'(bus_if.binary), 'hFF);
    chk("upwrap_g80", 32'(bus_if.gray), 'h80);
    chk("upwrap_nowrap", 32'(bus_if.wrap), 0);
    cyc(0, 0, 0, 1, 1);
    chk("upwrap_00", 32'(bus_if.binary), 0);
    chk("upwrap_g00", 32'(bus_if.gray), 0);
    chk("upwrap_wrap", 32'(bus_if.wrap), 1);
    chk("upwrap_idx", 32'(bus_if.flip_idx), 7);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    chk("dnwrap_ff", 32'(bus_if.binary), 'hFF);
    chk("dnwrap_g80", 32'(bus_if.gray), 'h80);
    chk("dnwrap_wrap", 32'(bus_if.wrap), 1);
    chk("dnwrap_idx", 32'(bus_if.flip_idx), 7);
    cyc(0, 0, 0, 1, 0);
    chk("dn_fe", 32'(bus_if.binary), 'hFE);
    chk("dn_g81", 32'(bus_if.gray), 'h81);
    chk("dn_idx", 32'(bus_if.flip_idx), 0);
    chk("dn_nowrap", 32'(bus_if.wrap), 0);
    cyc(0, 1, 'h5A, 1, 1);
    chk("prio_binary", 32'(bus_if.binary), 'h5A);
    chk("prio_gray", 32'(bus_if.gray), 'h77);
    chk("prio_flags", {bus_if.wrap, bus_if.flip_valid}, 0);
    cyc(1, 1, 'hA5, 1, 1);
    chk("rstld_binary", 32'(bus_if.binary), 0);
    chk("rstld_gray", 32'(bus_if.gray), 0);
    chk("rstld_flags", {bus_if.wrap, bus_if.flip_valid}, 0);
    ud = 1'b1;
    for (int i = 0; i < 512; i++) begin
      if (i == 256) ud = 1'b0;
      if ($urandom_range(0, 6) == 0) ud = ~ud;
      cyc(0, 0, 0, 1, ud);
    end
`ifdef GRAY_COUNTER_CHECK_EN
    cyc(0, 1, 'h10, 0, 1);
    cyc(0, 0, 0, 1, 1);
    chk_on = 1'b0;
    force bus_if.gray = 8'h1B;
    chk("err_before", 32'(bus_if.err), 0);
    cyc(0, 0, 0, 0, 1);
    chk("err_pulse", 32'(bus_if.err), 1);
    release bus_if.gray;
    cyc(0, 0, 0, 0, 1);
    chk("err_clear", 32'(bus_if.err), 0);
    cyc(0, 1, 0, 0, 1);
    chk_on = 1'b1;
    cyc(0, 0, 0, 1, 1);
`endif
    cyc(0, 0, 0, 0, 1);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/gray_counter_encoder.md
Name: gray_counter_encoder

Overview:
- Synchronous up/down counter that keeps a binary count and drives its registered Gray-code image, gray = bin ^ (bin >> 1). This is the encode direction of the team's Gray-to-binary decoder.
- Used to generate Gray-coded pointers and positions for clock-crossing and encoder-emulation paths.
- Also reports which Gray bit toggled on each step, so downstream logic and benches can check the single-bit-change property.

Parameters:
- WIDTH, 8, counter and code width in bits; must be ≥2.
- IDXW, $clog2(WIDTH), width of the flip_idx output; derived, do not override.

Ports:
- clk  input  1  clock; all logic updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  step request; one step per cycle while high.
- up_dn  input  1  step direction: 1 = increment, 0 = decrement.
- load  input  1  load request.
- load_bin  input  WIDTH  binary value to load.
- binary  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray code of binary.
- wrap  output  1  one-cycle pulse when a step wrapped the count.
- flip_valid  output  1  one-cycle pulse when the last update was a step.
- flip_idx  output  IDXW  index of the Gray bit that toggled on the last step.

Behaviour:
- Reset and clocking:
  - One clock domain, clk.
  - rst is synchronous and active-high.
  - Reset values: binary=0, gray=0, wrap=0, flip_valid=0, flip_idx=0.
  - rst overrides load and en in the same cycle.
- Priority each cycle: rst > load > en > hold.
- Load (load=1):
  - binary <= load_bin.
  - gray <= load_bin ^ (load_bin >> 1).
  - wrap <= 0, flip_valid <= 0, flip_idx holds.
  - en is ignored in that cycle.
- Step up (en=1, up_dn=1, load=0):
  - binary <= binary + 1, modulo 2^WIDTH.
  - wrap <= 1 only if binary was all-ones.
  - flip_idx <= count of trailing ones of the old binary, capped at WIDTH-1.
  - flip_valid <= 1.
- Step down (en=1, up_dn=0, load=0):
  - binary <= binary - 1, modulo 2^WIDTH.
  - wrap <= 1 only if binary was 0.
  - flip_idx <= count of trailing zeros of the old binary, capped at WIDTH-1.
  - flip_valid <= 1.
- Hold (en=0, load=0):
  - binary and gray hold.
  - wrap and flip_valid return to 0; flip_idx holds.
- Latency and register rules:
  - All outputs are registered; each reflects an input one cycle after the sampling edge.
  - gray is computed from the next binary value and registered alongside it. It must never lag binary, including on load.
- Single-bit change: across any step (not load), the new gray differs from the previous gray in exactly bit flip_idx.
- Wrap boundaries:
  - Up from all-ones goes to 0; gray goes from 100..0 to 0, bit WIDTH-1 toggles.
  - Down from 0 goes to all-ones; bit WIDTH-1 toggles.
- Direction change: up_dn may change on any cycle. The step direction is taken from up_dn as sampled with en; there is no extra latency.
- Reset mid-count: counting resumes from 0 on the first cycle after rst deasserts.

Optional Feature:
- Macro: GRAY_COUNTER_CHECK_EN.
- When defined:
  - Adds output port err (1 bit, reset 0).
  - The block keeps a registered copy of the previous gray.
  - After every step, err asserts for one cycle if popcount(gray ^ prev_gray) != 1, or if the toggled bit != flip_idx.
  - Load and reset cycles are excluded from the check; prev_gray is refreshed on every update.
- When undefined: no err port and no checker logic. Behaviour is otherwise identical.

Test Plan (WIDTH=8):
- Reset then count up: hold rst 2 cycles, then en=1, up_dn=1 for 5 cycles -> binary 1,2,3,4,5; gray 01,03,02,06,07 hex; flip_idx 0,1,0,2,0; wrap=0.
- Up wrap: load load_bin=FE, then 2 up steps -> binary FF then 00; gray 80 then 00; wrap=1 only on the 00 cycle; flip_idx=7 on that cycle.
- Down wrap: from reset, 1 down step -> binary FF, gray 80, wrap=1, flip_idx=7. Next down step -> FE, gray 81, flip_idx=0.
- Priority: load=1, en=1, load_bin=5A in the same cycle -> binary 5A, gray 77, flip_valid=0, wrap=0. Then rst=1 together with load=1 -> all outputs 0.
- Exhaustive walk: 256 up steps then 256 down steps, with a random direction flip every ~7 cycles -> gray always equals binary^(binary>>1) and exactly one bit changes per step; with GRAY_COUNTER_CHECK_EN, err is never asserted.
- Checker negative test (GRAY_COUNTER_CHECK_EN, bench force): force gray to 2 bits different from the previous value for one step -> err=1 for exactly one cycle.
